osd_spi_sequencer: RTL

Generates the SPI command stream that drives the OSD overlay's SPI slave port (`sck`/`ss`/`sdi`). It services two on-chip requesters, for example a status-line writer and a debug-page writer:
- arbitrates between them;
- serializes OSD enable/disable and line-write commands;
- fetches payload bytes from the granted requester through a shared one-cycle-latency read port.

It sits between the core's control logic and the OSD module, replacing an external IO controller when the core draws its own overlay.

---
 rtl/osd_spi_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/osd_spi_sequencer.sv
// SPI mode-0 command sequencer for the OSD overlay: arbitrates two requesters and streams payload.
// Define OSD_SEQ_RR_EN for round-robin arbitration; without it requester 0 has fixed priority.
module osd_spi_sequencer #(
  parameter int SCK_DIV     = 2,
  parameter int SS_GAP      = 4,
  parameter int PAYLOAD_LEN = 256
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [1:0] req0_op,
  input  logic [2:0] req0_line,
  input  logic       req1_valid,
  input  logic [1:0] req1_op,
  input  logic [2:0] req1_line,
  output logic       req0_ack,
  output logic       req1_ack,
  output logic       req0_done,
  output logic       req1_done,
  output logic       rd_req,
  output logic       rd_sel,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       sck,
  output logic       ss,
  output logic       sdi
);

  localparam int GW = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
  localparam logic [4:0]    TICK_LAST = 5'(2 * SCK_DIV - 1);
  localparam logic [4:0]    TICK_HIGH = 5'(SCK_DIV);
  localparam logic [4:0]    HOLD_LAST = 5'(SCK_DIV - 1);
  localparam logic [8:0]    BYTE_LAST = 9'(PAYLOAD_LEN);
  localparam logic [GW-1:0] GAP_LAST  = GW'(SS_GAP - 1);

  localparam logic [1:0] OP_DIS = 2'b00;
  localparam logic [1:0] OP_EN  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {IDLE, GRANT, SHIFT, HOLD, DONE, GAP} state_t;

  state_t          state, state_n;
  logic            owner;
  logic [1:0]      op_q;
  logic [4:0]      tick;
  logic [2:0]      bit_cnt;
  logic [8:0]      cur_byte;
  logic [7:0]      shreg;
  logic [7:0]      next_byte;
  logic            rd_pending;
  logic [GW-1:0]   gap_cnt;
  logic            any_req;
  logic            pick;
  logic [1:0]      pick_op;
  logic [2:0]      pick_line;
  logic [7:0]      cmd_byte;
  logic            bit_end;
  logic            byte_end;
  logic            more;

`ifdef OSD_SEQ_RR_EN
  logic rr_ptr;

  // Pointer names the requester that wins the next simultaneous contention.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset)
      rr_ptr <= 1'b0;
    else if (state == IDLE && any_req)
      rr_ptr <= ~pick;
  end
`endif

  always_comb begin
    any_req = req0_valid | req1_valid;
`ifdef OSD_SEQ_RR_EN
    pick = (req0_valid && req1_valid) ? rr_ptr : !req0_valid;
`else
    pick = !req0_valid;
`endif
    pick_op   = pick ? req1_op : req0_op;
    pick_line = pick ? req1_line : req0_line;
    case (pick_op)
      OP_DIS:  cmd_byte = 8'h40;
      OP_EN:   cmd_byte = 8'h41;
      default: cmd_byte = {5'b00100, pick_line};
    endcase
  end

  assign bit_end  = (tick == TICK_LAST);
  assign byte_end = bit_end && (bit_cnt == 3'd0);
  assign more     = (op_q == OP_WR) && (cur_byte < BYTE_LAST);

  always_ff @(posedge pclk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // GRANT doubles as the first low cycle of the command MSB, so SHIFT resumes at tick 1.
  always_comb begin
    state_n   = state;
    ss        = 1'b1;
    sck       = 1'b0;
    sdi       = 1'b0;
    req0_ack  = 1'b0;
    req1_ack  = 1'b0;
    req0_done = 1'b0;
    req1_done = 1'b0;
    rd_req    = 1'b0;
    busy      = (state != IDLE);
    rd_sel    = owner;
    rd_addr   = cur_byte[7:0];
    case (state)
      IDLE: if (any_req) state_n = GRANT;
      GRANT: begin
        req0_ack = !owner;
        req1_ack = owner;
        if (op_q != OP_RSV) begin
          ss  = 1'b0;
          sdi = shreg[7];
        end
        state_n = (op_q == OP_RSV) ? DONE : SHIFT;
      end
      SHIFT: begin
        ss     = 1'b0;
        sdi    = shreg[7];
        sck    = (tick >= TICK_HIGH);
        rd_req = more && (bit_cnt == 3'd0) && (tick == 5'd0);
        if (byte_end && !more) state_n = HOLD;
      end
      HOLD: begin
        ss  = 1'b0;
        sdi = shreg[7];
        if (tick == HOLD_LAST) state_n = DONE;
      end
      DONE: begin
        req0_done = !owner;
        req1_done = owner;
        state_n   = GAP;
      end
      GAP: if (gap_cnt == GAP_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Fetched byte arrives one cycle after rd_req; with SCK_DIV=1 that is the boundary cycle itself.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      owner      <= 1'b0;
      op_q       <= 2'b00;
      tick       <= 5'd0;
      bit_cnt    <= 3'd0;
      cur_byte   <= 9'd0;
      shreg      <= 8'h00;
      next_byte  <= 8'h00;
      rd_pending <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      rd_pending <= rd_req;
      if (rd_pending) next_byte <= rd_data;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= pick;
            op_q     <= pick_op;
            shreg    <= cmd_byte;
            bit_cnt  <= 3'd7;
            cur_byte <= 9'd0;
          end
        end
        GRANT: tick <= 5'd1;
        SHIFT: begin
          if (bit_end) begin
            tick <= 5'd0;
            if (bit_cnt == 3'd0) begin
              bit_cnt  <= 3'd7;
              cur_byte <= cur_byte + 9'd1;
              if (more) shreg <= rd_pending ? rd_data : next_byte;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
              shreg   <= {shreg[6:0], 1'b0};
            end
          end else begin
            tick <= tick + 5'd1;
          end
        end
        HOLD: tick <= tick + 5'd1;
        DONE: gap_cnt <= '0;
        GAP:  gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

endmodule
